// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between the instruction fetch
// unit and the load/store unit, one outstanding transaction at a time.
//
//   state | meaning
//   IDLE  | no transaction; grant one requester (round-robin on a tie)
//   REQ   | latched request presented to memory, waiting for mem_req_ready
//   WAIT  | request accepted by memory, waiting for mem_rsp_valid
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_addr,
  output logic            ifu_rsp_valid,
  output logic [DW-1:0]   ifu_rdata,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic [AW-1:0]   lsu_addr,
  input  logic            lsu_wen,
  input  logic [DW-1:0]   lsu_wdata,
  input  logic [DW/8-1:0] lsu_wmask,
  output logic            lsu_rsp_valid,
  output logic [DW-1:0]   lsu_rdata,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_rsp_valid,
  input  logic [DW-1:0]   mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic SRC_IFU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  state_t          state;
  state_t          state_nxt;
  logic            owner;
  logic            last_grant;
  logic            grant_ifu;
  logic            grant_lsu;
  logic            rsp_hit;
  logic [AW-1:0]   req_addr;
  logic            req_wen;
  logic [DW-1:0]   req_wdata;
  logic [DW/8-1:0] req_wmask;

  // Grant decision and next-state logic; a tie goes to whoever was not granted last.
  always_comb begin
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    rsp_hit   = 1'b0;
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ifu_req_valid && lsu_req_valid) begin
          if (last_grant == SRC_IFU) grant_lsu = 1'b1;
          else                       grant_ifu = 1'b1;
        end else begin
          grant_ifu = ifu_req_valid;
          grant_lsu = lsu_req_valid;
        end
        if (grant_ifu || grant_lsu) state_nxt = REQ;
      end
      REQ: begin
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: begin
        rsp_hit = mem_rsp_valid;
        if (mem_rsp_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and request latch; the winner's payload is captured on the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= SRC_IFU;
      last_grant <= SRC_IFU;
      req_addr   <= '0;
      req_wen    <= 1'b0;
      req_wdata  <= '0;
      req_wmask  <= '0;
    end else begin
      state <= state_nxt;
      if (grant_ifu || grant_lsu) begin
        owner      <= grant_lsu;
        last_grant <= grant_lsu;
        req_addr   <= grant_lsu ? lsu_addr : ifu_addr;
        req_wen    <= grant_lsu & lsu_wen;
        req_wdata  <= grant_lsu ? lsu_wdata : '0;
        req_wmask  <= grant_lsu ? lsu_wmask : '0;
      end
    end
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  assign mem_req_valid = (state == REQ);
  assign mem_addr      = req_addr;
  assign mem_wen       = req_wen;
  assign mem_wdata     = req_wdata;
  assign mem_wmask     = req_wmask;

  // Responses are only forwarded in WAIT, so stray responses and reset-dropped ones vanish.
  assign ifu_rsp_valid = rsp_hit && (owner == SRC_IFU);
  assign lsu_rsp_valid = rsp_hit && (owner == SRC_LSU);
  assign ifu_rdata     = ifu_rsp_valid ? mem_rdata : '0;
  assign lsu_rdata     = lsu_rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [AW-1:0]   ifu_addr;
  logic [DW-1:0]   ifu_rdata;
  logic            lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid;
  logic [AW-1:0]   lsu_addr;
  logic [DW-1:0]   lsu_wdata, lsu_rdata;
  logic [DW/8-1:0] lsu_wmask;
  logic            mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;
  logic [DW/8-1:0] mem_wmask;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: is a transaction outstanding, has memory taken it yet,
  // who owns it, who won the last grant, and the captured payload.
  bit              m_busy, m_issued, m_owner, m_last;
  logic [AW-1:0]   m_addr;
  logic            m_wen;
  logic [DW-1:0]   m_wdata;
  logic [DW/8-1:0] m_wmask;
  bit              g_ifu, g_lsu, hs_ifu, hs_lsu;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called right after a negedge with inputs already driven.
  task automatic eval();
    bit r_ifu, r_lsu;
    #1;
    g_ifu = !m_busy && ifu_req_valid && (!lsu_req_valid || m_last);
    g_lsu = !m_busy && lsu_req_valid && (!ifu_req_valid || !m_last);
    r_ifu = m_busy && m_issued && mem_rsp_valid && !m_owner;
    r_lsu = m_busy && m_issued && mem_rsp_valid && m_owner;
    chk("ifu_req_ready", ifu_req_ready, g_ifu);
    chk("lsu_req_ready", lsu_req_ready, g_lsu);
    chk("ifu_rsp_valid", ifu_rsp_valid, r_ifu);
    chk("lsu_rsp_valid", lsu_rsp_valid, r_lsu);
    chk("ifu_rdata", ifu_rdata, r_ifu ? mem_rdata : '0);
    chk("lsu_rdata", lsu_rdata, r_lsu ? mem_rdata : '0);
    chk("mem_req_valid", mem_req_valid, m_busy && !m_issued);
    if (m_busy && !m_issued) begin
      chk("mem_addr", mem_addr, m_addr);
      chk("mem_wen", mem_wen, m_wen);
      chk("mem_wmask", mem_wmask, m_wmask);
      if (m_wen) chk("mem_wdata", mem_wdata, m_wdata);
    end
  endtask

  // Advance the model by one clock using the inputs of this cycle, then clock the DUT.
  task automatic adv();
    hs_ifu = !rst && g_ifu;
    hs_lsu = !rst && g_lsu;
    if (rst) begin
      m_busy = 0; m_issued = 0; m_last = 0;
    end else if (!m_busy) begin
      if (g_ifu || g_lsu) begin
        m_busy   = 1;
        m_issued = 0;
        m_owner  = g_lsu;
        m_last   = g_lsu;
        m_addr   = g_lsu ? lsu_addr : ifu_addr;
        m_wen    = g_lsu && lsu_wen;
        m_wdata  = lsu_wdata;
        m_wmask  = g_lsu ? lsu_wmask : '0;
      end
    end else if (!m_issued) begin
      if (mem_req_ready) m_issued = 1;
    end else if (mem_rsp_valid) begin
      m_busy = 0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    eval();
    adv();
  endtask

  initial begin
    rst = 1; ifu_req_valid = 0; ifu_addr = '0; lsu_req_valid = 0; lsu_addr = '0;
    lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0; mem_req_ready = 0; mem_rsp_valid = 0;
    mem_rdata = '0;
    m_busy = 0; m_issued = 0; m_owner = 0; m_last = 0;
    m_addr = '0; m_wen = 0; m_wdata = '0; m_wmask = '0;
    @(posedge clk); @(negedge clk);
    cyc(); cyc();
    rst = 0;
    cyc();

    // IFU-only fetch at minimum latency.
    ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
    eval(); chk("fetch_ready_c0", ifu_req_ready, 1'b1); adv();
    ifu_req_valid = 0; ifu_addr = '0;
    eval();
    chk("fetch_mem_valid_c1", mem_req_valid, 1'b1);
    chk("fetch_mem_addr_c1", mem_addr, 32'h8000_0000);
    chk("fetch_mem_wen_c1", mem_wen, 1'b0);
    adv();
    mem_rsp_valid = 1; mem_rdata = 32'h0000_0413;
    eval();
    chk("fetch_rsp_c2", ifu_rsp_valid, 1'b1);
    chk("fetch_rdata_c2", ifu_rdata, 32'h0000_0413);
    chk("fetch_lsu_quiet_c2", lsu_rsp_valid, 1'b0);
    adv();
    mem_rsp_valid = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
    eval(); chk("fetch_next_accept_c3", ifu_req_ready, 1'b1); adv();
    ifu_req_valid = 0;
    cyc(); mem_rsp_valid = 1; cyc(); mem_rsp_valid = 0;

    // LSU store.
    lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 1;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
    cyc();
    lsu_req_valid = 0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0; lsu_wen = 0;
    eval();
    chk("store_addr", mem_addr, 32'h8000_1000);
    chk("store_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("store_wmask", mem_wmask, 4'hF);
    chk("store_wen", mem_wen, 1'b1);
    adv();
    mem_rsp_valid = 1;
    eval(); chk("store_done", lsu_rsp_valid, 1'b1); adv();
    mem_rsp_valid = 0;
    eval(); chk("store_done_once", lsu_rsp_valid, 1'b0); adv();

    // Ties right after reset: LSU first, then alternate.
    rst = 1; cyc(); rst = 0;
    ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
    lsu_req_valid = 1; lsu_addr = 32'h8000_2000; lsu_wen = 0;
    mem_req_ready = 1; mem_rsp_valid = 1;
    for (int k = 0; k < 4; k++) begin
      eval();
      chk("tie_lsu_grant", lsu_req_ready, (k % 2 == 0));
      chk("tie_ifu_grant", ifu_req_ready, (k % 2 == 1));
      adv();
      cyc(); cyc();
    end
    ifu_req_valid = 0; lsu_req_valid = 0; mem_rsp_valid = 0;
    cyc();

    // Backpressure: memory stalls for five cycles with both requesters pending.
    lsu_req_valid = 1; lsu_addr = 32'h8000_3000; lsu_wen = 1;
    lsu_wdata = 32'h1234_5678; lsu_wmask = 4'h5; mem_req_ready = 0;
    cyc();
    ifu_req_valid = 1; lsu_addr = 32'h0BAD_0BAD; lsu_wdata = 32'h0; lsu_wmask = 4'hA;
    for (int k = 0; k < 5; k++) begin
      eval();
      chk("bp_valid", mem_req_valid, 1'b1);
      chk("bp_addr", mem_addr, 32'h8000_3000);
      chk("bp_wdata", mem_wdata, 32'h1234_5678);
      chk("bp_wmask", mem_wmask, 4'h5);
      chk("bp_readys", {ifu_req_ready, lsu_req_ready}, 2'b00);
      adv();
    end
    ifu_req_valid = 0; lsu_req_valid = 0; lsu_wen = 0; mem_req_ready = 1;
    cyc(); mem_rsp_valid = 1; cyc(); mem_rsp_valid = 0;

    // Reset while waiting for the response, then a stray response.
    lsu_req_valid = 1; lsu_addr = 32'h8000_4000;
    cyc();
    lsu_req_valid = 0;
    cyc();
    rst = 1;
    cyc();
    rst = 0; mem_rsp_valid = 1; mem_rdata = 32'hCAFE_F00D; ifu_req_valid = 1;
    eval();
    chk("rst_drop_ifu_rsp", ifu_rsp_valid, 1'b0);
    chk("rst_drop_lsu_rsp", lsu_rsp_valid, 1'b0);
    chk("rst_idle_accept", ifu_req_ready, 1'b1);
    adv();
    ifu_req_valid = 0; mem_rsp_valid = 0;
    cyc(); mem_rsp_valid = 1; cyc(); mem_rsp_valid = 0;

    // Random traffic; requesters hold valid and payload until accepted.
    hs_ifu = 0; hs_lsu = 0;
    for (int n = 0; n < 4000; n++) begin
      if (!ifu_req_valid || hs_ifu) begin
        ifu_req_valid = ($urandom_range(0, 1) == 1);
        ifu_addr      = $urandom;
      end
      if (!lsu_req_valid || hs_lsu) begin
        lsu_req_valid = ($urandom_range(0, 1) == 1);
        lsu_addr      = $urandom;
        lsu_wen       = $urandom_range(0, 1);
        lsu_wdata     = $urandom;
        lsu_wmask     = 4'($urandom);
      end
      mem_req_ready = ($urandom_range(0, 1) == 1);
      mem_rsp_valid = ($urandom_range(0, 4) < 2);
      mem_rdata     = $urandom;
      rst           = ($urandom_range(0, 199) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between the instruction fetch unit (IFU) and the load/store unit (LSU).
- Accepts one request at a time from either side and drives it onto the memory port with a valid/ready handshake.
- Routes the memory response back to the requester that issued it.
- Sits between the IFU/LSU and the memory model (DPI-C or bus bridge). Only one transaction is outstanding at any time.

Parameters:
- AW, 32, address width.
- DW, 32, data width; the write mask is DW/8 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ifu_req_valid  in  1  IFU fetch request
- ifu_req_ready  out  1  arbiter accepts IFU request
- ifu_addr  in  AW  fetch address
- ifu_rsp_valid  out  1  fetch data valid, one-cycle pulse
- ifu_rdata  out  DW  fetch data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  arbiter accepts LSU request
- lsu_addr  in  AW  load/store address
- lsu_wen  in  1  1 = store, 0 = load
- lsu_wdata  in  DW  store data
- lsu_wmask  in  DW/8  store byte mask
- lsu_rsp_valid  out  1  load data or store completion, one-cycle pulse
- lsu_rdata  out  DW  load data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  AW  address
- mem_wen  out  1  write enable
- mem_wdata  out  DW  write data
- mem_wmask  out  DW/8  write mask
- mem_rsp_valid  in  1  memory response, one cycle
- mem_rdata  in  DW  read data

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- State machine: IDLE, REQ, WAIT. Registers: state, owner (IFU/LSU), last_grant (IFU/LSU), and a latched request (addr, wen, wdata, wmask).
- Reset values:
  - state = IDLE, last_grant = IFU, latched request = 0.
  - All outputs 0 except ifu_req_ready/lsu_req_ready, which follow the IDLE grant rule below.
- IDLE:
  - Grant is combinational. Only IFU valid -> ifu_req_ready = 1. Only LSU valid -> lsu_req_ready = 1.
  - Both valid -> round-robin: grant goes to the requester that is not last_grant. The first tie after reset therefore goes to the LSU.
  - The ready of the non-granted requester is 0.
  - On a handshake (valid & ready): latch the request and set owner = last_grant = winner.
  - IFU requests latch wen = 0 and wmask = 0.
  - Next state is REQ.
- REQ:
  - mem_req_valid = 1 and mem_* = latched fields, held stable until mem_req_ready.
  - mem_req_ready = 1 -> WAIT.
  - Both requester readys are 0.
- WAIT:
  - mem_req_valid = 0.
  - On mem_rsp_valid = 1: <owner>_rsp_valid = 1 in the same cycle (combinational), and <owner>_rdata = mem_rdata. Next state is IDLE.
  - Stores also complete via mem_rsp_valid; lsu_rdata is don't-care for stores.
- Response outputs:
  - The non-owner's rsp_valid is always 0.
  - rdata outputs are mem_rdata gated to 0 when the corresponding rsp_valid = 0.
- No request acceptance in REQ or WAIT. A requester must hold valid and payload until it sees ready.
- Minimum latency, with memory ready and responding in the earliest cycles:
  - Handshake in cycle 0.
  - mem_req_valid in cycle 1.
  - Response in cycle 2.
  - Next acceptance in cycle 3.
- Boundary cases:
  - mem_rsp_valid in IDLE or REQ is a protocol violation: ignored, no rsp forwarded.
  - Reset mid-transaction: return to IDLE, drop the transaction, never forward its response; last_grant returns to IFU.
  - Requester drops valid after the handshake: no effect, because the request is already latched.
  - A new request may be presented in the same cycle as rsp_valid. It is accepted the following cycle in IDLE.

Test Plan:
- IFU-only fetch: ifu_addr = 0x80000000 valid in cycle 0, mem ready immediately, mem_rsp_valid in cycle 2 with rdata = 0x00000413 -> mem_addr = 0x80000000 and wen = 0 in cycle 1; ifu_rsp_valid = 1 with rdata 0x00000413 in cycle 2; lsu_rsp_valid stays 0.
- LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, wen = 1 -> mem_* carries exact values in REQ; lsu_rsp_valid pulses once on the memory response.
- Simultaneous requests after reset, held for two transactions -> LSU served first, then IFU. Repeating the tie alternates IFU/LSU.
- Backpressure: mem_req_ready low for 5 cycles -> mem_req_valid and all mem_* fields stable for all 5 cycles; both requester readys 0 throughout.
- Reset asserted in WAIT, then a stray mem_rsp_valid the cycle after reset -> no rsp_valid on either side; state is IDLE; ifu_req_ready responds to a new request in the next cycle.
